clock_div_100: RTL and testbench
================================

Name: clock_div_100

Overview:
- Free-running divide-by-DIV clock-enable generator; default DIV=100 turns the 100 MHz system clock into a 1 us time base.
- Outputs a square divided clock plus single-cycle rising/falling edge pulses in the clk domain.
- Consumers such as the UART transmitter's microsecond counter use the falling-edge pulse as a count enable; the divided clock is never used as a clock.

Parameters:
- DIV, 100, division ratio; must be even and >= 2.
- CNT_W, 7, counter width; must satisfy 2**CNT_W >= DIV.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_p  input  1  asynchronous, active-high reset.
- clk_div_100  output  1  divided clock, period DIV clk cycles, 50% duty.
- clk_div_100_pedge  output  1  one-clk-cycle pulse on each rising edge of clk_div_100.
- clk_div_100_nedge  output  1  one-clk-cycle pulse on each falling edge of clk_div_100.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, reset_p).
- Counter cnt (CNT_W bits):
  - Reset value 0.
  - On each posedge clk, cnt increments by 1.
  - On reaching DIV-1 it wraps to 0 on the next posedge.
  - cnt never holds a value >= DIV.
- clk_div_100:
  - Decoded from the registered cnt: 0 while cnt < DIV/2, 1 while cnt >= DIV/2.
  - Default DIV gives low for cnt 0..49 and high for cnt 50..99.
- Edge history: register prev samples clk_div_100 on every posedge clk; reset value 0.
- Pulse outputs:
  - pedge = clk_div_100 & ~prev; nedge = ~clk_div_100 & prev.
  - Both are derived only from registers, so they are glitch-free.
  - Each stays stable for a full clk period, so a consumer may sample on either clk edge.
- Timing after reset release, counting posedges (N = number of posedges since release):
  - pedge is high for exactly one cycle when cnt == DIV/2, first at N=50.
  - nedge is high for exactly one cycle when cnt == 0 after a wrap, first at N=100, then every DIV cycles.
  - No nedge is produced in the cnt == 0 cycle directly after reset, because prev resets to 0.
- Reset outputs: clk_div_100=0, pedge=0, nedge=0.
- Mutual exclusion: pedge and nedge are never high in the same cycle.
- Pulse count: each pulse occurs exactly once per DIV-cycle period.
- Reset mid-operation: cnt and prev clear immediately (asynchronously). All outputs go to 0 with no spurious pulse; the sequence restarts from N=0.
- No enable input and no handshake; the block runs continuously.

Decomposition:
- Shared package: DIV_100 = 100 and the derived CNT_W constant; no typedefs.
- One sub-module, edge_detector:
  - Ports: clk, reset_p, cp (input), p_edge, n_edge.
  - Holds the prev register and the pulse logic.
  - Reusable by other dividers (e.g. a divide-by-1000 ms tick).
- Top level holds the counter, the duty-cycle decode and the edge_detector instance.

Test Plan:
- Reset hold: reset_p=1 for 20 ns with clk running -> all outputs 0, cnt=0; no pulse during or in the first cycle after release.
- Steady state, DIV=100, 100 MHz clk, over 10 periods:
  - clk_div_100 low 500 ns, high 500 ns.
  - nedge pulses exactly 10 ns wide, spaced exactly 1000 ns.
  - First nedge at posedge 100 after release.
- Edge pairing: first pedge at posedge 50. Over 1000 cycles: 10 pedge, 10 nedge, never coincident, with pedge-to-nedge spacing of 50 cycles.
- Async reset mid-period: assert reset_p at cnt=73 for 15 ns -> outputs 0 immediately. After release, next pedge after 50 posedges and next nedge after 100; no extra pulse.
- Wrap boundary: check cnt sequence 98, 99, 0, 1 and that cnt never reaches 100. Repeat with DIV=4: clk_div_100 pattern 0,0,1,1 and nedge every 4 cycles.
- Consumer check: drive a counter on negedge clk enabled by nedge -> increments once per 1000 ns, reaching 5 after 5 us.

Source files
------------

// File: rtl/clock_div_100_pkg.sv
// Shared constants for the microsecond time-base divider.
// CNT_W_100 is derived from DIV_100, so changing the ratio keeps the counter wide enough.
package clock_div_100_pkg;
   localparam int DIV_100   = 100;
   localparam int CNT_W_100 = $clog2(DIV_100);
endpackage : clock_div_100_pkg

// File: rtl/clock_div_100_edge_detector.sv
// Registered edge detector for a slow, register-derived level.
// Produces one-clk-cycle pulses on the rising and falling transitions of cp.
// Suits any divider that needs tick pulses, for example a divide-by-1000 ms tick.
module edge_detector
   import clock_div_100_pkg::*;
(
   input  logic clk,
   input  logic reset_p,
   input  logic cp,
   output logic p_edge,
   output logic n_edge
);

   logic prev_q;

   // History of cp. It resets to 0, so a low cp coming out of reset gives no falling pulse.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         prev_q <= 1'b0;
      end else begin
         prev_q <= cp;
      end
   end

   // cp comes from registers, so both pulses hold steady for the whole clk period.
   assign p_edge = cp & ~prev_q;
   assign n_edge = ~cp & prev_q;

endmodule : edge_detector

// File: rtl/clock_div_100.sv
// Free-running divide-by-DIV clock-enable generator.
// Gives a 50% duty divided level plus rising and falling edge pulses in the clk domain.
// The divided output is a data level for enables. Do not use it as a clock.
module clock_div_100
   import clock_div_100_pkg::*;
#(
   parameter int DIV   = DIV_100,
   parameter int CNT_W = CNT_W_100
) (
   input  logic clk,
   input  logic reset_p,
   output logic clk_div_100,
   output logic clk_div_100_pedge,
   output logic clk_div_100_nedge
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: wrap from DIV-1 to 0, so the counter never reaches DIV.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end
   end

   // Period counter. It clears asynchronously so a mid-period reset restarts the time base at once.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Low for the first half of the period and high for the second half.
   assign clk_div_100 = (cnt_q >= CNT_HALF);

   edge_detector u_edge_detector (
      .clk     (clk),
      .reset_p (reset_p),
      .cp      (clk_div_100),
      .p_edge  (clk_div_100_pedge),
      .n_edge  (clk_div_100_nedge)
   );

endmodule : clock_div_100

// File: tb/tb_clock_div_100.sv
// Bench for clock_div_100: the default DIV=100 instance and a DIV=4 instance.
`timescale 1ns/1ps
module tb_clock_div_100;

   logic clk;
   logic reset_p;
   logic div_o, ped_o, ned_o;
   logic div4_o, ped4_o, ned4_o;

   int checks;
   int errors;
   int n;            // posedges since the last reset release
   int cons;         // consumer counter, enabled by nedge
   int p_cnt, n_cnt, last_p, coinc;

   clock_div_100 dut (
      .clk               (clk),
      .reset_p           (reset_p),
      .clk_div_100       (div_o),
      .clk_div_100_pedge (ped_o),
      .clk_div_100_nedge (ned_o)
   );

   clock_div_100 #(.DIV(4), .CNT_W(2)) dut4 (
      .clk               (clk),
      .reset_p           (reset_p),
      .clk_div_100       (div4_o),
      .clk_div_100_pedge (ped4_o),
      .clk_div_100_nedge (ned4_o)
   );

   // Clock and watchdog.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // Consumer: counts microseconds on negedge, enabled by the falling-edge pulse.
   always @(negedge clk) begin
      if (reset_p) cons <= 0;
      else if (ned_o) cons <= cons + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at n=%0d: actual=%0d required=%0d", name, n, act, exp);
      end
   endtask

   // Independent model of both instances, indexed by posedges since release.
   task automatic check_model();
      int c, c4;
      c  = n % 100;
      c4 = n % 4;
      check("cnt",      int'(dut.cnt_q), c);
      check("cnt_lt_div", int'(dut.cnt_q < 7'd100), 1);
      check("div",      int'(div_o), int'(c >= 50));
      check("pedge",    int'(ped_o), int'(c == 50));
      check("nedge",    int'(ned_o), int'(c == 0 && n > 0));
      check("cnt4",     int'(dut4.cnt_q), c4);
      check("div4",     int'(div4_o), int'(c4 >= 2));
      check("pedge4",   int'(ped4_o), int'(c4 == 2));
      check("nedge4",   int'(ned4_o), int'(c4 == 0 && n > 0));
   endtask

   // Advance one posedge, then sample on the following negedge.
   task automatic step();
      @(posedge clk);
      n++;
      @(negedge clk);
   endtask

   task automatic run_model(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         step();
         check_model();
         if (ped_o) begin
            p_cnt++;
            last_p = n;
         end
         if (ned_o) begin
            n_cnt++;
            if (last_p >= 0) check("p_to_n_spacing", n - last_p, 50);
         end
         if (ped_o && ned_o) coinc++;
      end
   endtask

   typedef struct {
      int   n;
      int   cnt;
      logic dv;
      logic pe;
      logic ne;
   } vec_t;

   vec_t vecs[12];

   initial begin
      checks = 0;
      errors = 0;
      n      = 0;
      last_p = -1;

      vecs[0]  = '{0,   0,  1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1,   1,  1'b0, 1'b0, 1'b0};
      vecs[2]  = '{49,  49, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{50,  50, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{51,  51, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{98,  98, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{99,  99, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{100, 0,  1'b0, 1'b0, 1'b1};
      vecs[8]  = '{101, 1,  1'b0, 1'b0, 1'b0};
      vecs[9]  = '{150, 50, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{199, 99, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{200, 0,  1'b0, 1'b0, 1'b1};

      // Reset hold for 20 ns with the clock running.
      reset_p = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("rst_cnt",   int'(dut.cnt_q), 0);
         check("rst_div",   int'(div_o), 0);
         check("rst_pedge", int'(ped_o), 0);
         check("rst_nedge", int'(ned_o), 0);
      end
      reset_p = 1'b0;
      n = 0;

      // Table-driven checks. The N=0 entry is the first cycle after release.
      for (int v = 0; v < 12; v++) begin
         while (n < vecs[v].n) step();
         check("vec_cnt",   int'(dut.cnt_q), vecs[v].cnt);
         check("vec_div",   int'(div_o), int'(vecs[v].dv));
         check("vec_pedge", int'(ped_o), int'(vecs[v].pe));
         check("vec_nedge", int'(ned_o), int'(vecs[v].ne));
      end

      // Steady state over 1000 cycles (10 periods), with pulse counts and spacing.
      p_cnt = 0; n_cnt = 0; coinc = 0;
      run_model(1000);
      check("pedge_count", p_cnt, 10);
      check("nedge_count", n_cnt, 10);
      check("coincident",  coinc, 0);

      // Asynchronous reset in mid-period, at cnt = 73.
      while ((n % 100) != 73) step();
      check("pre_rst_cnt", int'(dut.cnt_q), 73);
      #2 reset_p = 1'b1;
      #1;
      check("async_cnt",   int'(dut.cnt_q), 0);
      check("async_div",   int'(div_o), 0);
      check("async_pedge", int'(ped_o), 0);
      check("async_nedge", int'(ned_o), 0);
      check("async_cnt4",  int'(dut4.cnt_q), 0);
      #14 reset_p = 1'b0;   // 15 ns pulse, released 2 ns after a posedge
      @(negedge clk);
      n = 0;
      last_p = -1;
      check_model();

      // Restarted sequence: pedge after 50 posedges, nedge after 100, no extras.
      // Over 500 cycles the consumer must reach 5 after 5 us.
      p_cnt = 0; n_cnt = 0; coinc = 0;
      run_model(500);
      check("rst_pedge_count", p_cnt, 5);
      check("rst_nedge_count", n_cnt, 5);
      check("rst_coincident",  coinc, 0);
      #1;
      check("consumer_5us", cons, 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_clock_div_100
